// File: rtl/apb_master.sv
// apb_master: single-outstanding APB3 requester turning a valid/ready command stream into SETUP/ACCESS phases with a wait-state watchdog
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic              i_cmd_write,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [ADDR_W-1:0] o_paddr,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic              i_pready,
  input  logic              i_pslverr,
  input  logic [DATA_W-1:0] i_prdata,
  output logic              o_rsp_valid,
  output logic              o_rsp_err,
  output logic [DATA_W-1:0] o_rsp_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic accept, expire, done;
  assign o_cmd_ready = state == IDLE;
  always_comb begin
    accept   = state == IDLE && i_cmd_valid;
    expire   = !i_pready && cnt == CW'(TIMEOUT - 1);
    done     = state == ACCESS && (i_pready || expire);
    state_nx = accept ? SETUP : state == SETUP ? ACCESS : done ? IDLE : state;
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_psel      <= 1'b0;
      o_penable   <= 1'b0;
      o_pwrite    <= 1'b0;
      o_paddr     <= '0;
      o_pwdata    <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_rdata <= '0;
      cnt         <= '0;
    end else begin
      o_rsp_valid <= done;
      if (accept) begin
        o_psel    <= 1'b1;
        o_penable <= 1'b0;
        o_paddr   <= i_cmd_addr;
        o_pwrite  <= i_cmd_write;
        o_pwdata  <= i_cmd_wdata;
      end
      if (state == SETUP) begin
        o_penable <= 1'b1;
        cnt       <= '0;
      end
      if (state == ACCESS && !i_pready) cnt <= cnt + 1'b1;
      if (done) begin
        o_psel      <= 1'b0;
        o_penable   <= 1'b0;
        o_rsp_err   <= !i_pready || i_pslverr;
        o_rsp_rdata <= (i_pready && !o_pwrite && !i_pslverr) ? i_prdata : '0;
      end
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized self-checking bench for apb_master against a transaction-level model
module tb_apb_master;
  localparam int TO = 15;
  logic       i_clk = 1'b0;
  logic       i_reset_n, i_cmd_valid, i_cmd_write, i_pready, i_pslverr;
  logic [7:0] i_cmd_addr, i_cmd_wdata, i_prdata;
  logic       o_cmd_ready, o_psel, o_penable, o_pwrite, o_rsp_valid, o_rsp_err;
  logic [7:0] o_paddr, o_pwdata, o_rsp_rdata;
  int checks = 0;
  int errors = 0;
  apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_addr(i_cmd_addr), .i_cmd_write(i_cmd_write), .i_cmd_wdata(i_cmd_wdata),
    .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite),
    .o_paddr(o_paddr), .o_pwdata(o_pwdata),
    .i_pready(i_pready), .i_pslverr(i_pslverr), .i_prdata(i_prdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_err(o_rsp_err), .o_rsp_rdata(o_rsp_rdata)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_rsp", o_rsp_valid, 0);
      chk("idle_sel", {o_psel, o_penable}, 0);
      chk("idle_ready", o_cmd_ready, 1);
    end
  endtask
  // One transfer: slave answers after `waits` not-ready ACCESS cycles; waits>=TO never answers.
  task automatic txn(input logic [7:0] a, input logic w, input logic [7:0] wd,
                     input int waits, input logic se, input logic [7:0] rd);
    int n;
    logic ee;
    logic [7:0] er;
    n  = waits >= TO ? TO : waits + 1;
    ee = waits >= TO ? 1'b1 : se;
    er = (w || ee) ? 8'h00 : rd;
    i_cmd_valid = 1'b1;
    i_cmd_addr  = a;
    i_cmd_write = w;
    i_cmd_wdata = wd;
    chk("accept_ready", o_cmd_ready, 1);
    step();
    i_cmd_valid = 1'b0;
    i_cmd_addr  = 8'($urandom);
    i_cmd_wdata = 8'($urandom);
    i_cmd_write = 1'($urandom);
    chk("setup_sel", {o_psel, o_penable}, 2'b10);
    chk("setup_rsp", o_rsp_valid, 0);
    chk("setup_ready", o_cmd_ready, 0);
    chk("setup_addr", o_paddr, a);
    chk("setup_write", o_pwrite, w);
    if (w) chk("setup_wdata", o_pwdata, wd);
    step();
    for (int k = 0; k < n; k++) begin
      chk("acc_sel", {o_psel, o_penable}, 2'b11);
      chk("acc_addr", o_paddr, a);
      chk("acc_write", o_pwrite, w);
      chk("acc_ready", o_cmd_ready, 0);
      chk("acc_rsp", o_rsp_valid, 0);
      i_pready  = k == waits;
      i_pslverr = k == waits ? se : 1'($urandom);
      i_prdata  = k == waits ? rd : 8'($urandom);
      step();
    end
    i_pready  = 1'b0;
    i_pslverr = 1'b0;
    i_prdata  = 8'($urandom);
    chk("rsp_valid", o_rsp_valid, 1);
    chk("rsp_err", o_rsp_err, ee);
    chk("rsp_rdata", o_rsp_rdata, er);
    chk("rsp_sel", {o_psel, o_penable}, 0);
    chk("rsp_ready", o_cmd_ready, 1);
  endtask
  initial begin
    i_reset_n   = 1'b0;
    i_cmd_valid = 1'b1;
    i_cmd_addr  = 8'h99;
    i_cmd_write = 1'b1;
    i_cmd_wdata = 8'h66;
    i_pready    = 1'b0;
    i_pslverr   = 1'b0;
    i_prdata    = 8'h00;
    step();
    step();
    chk("rst_sel", {o_psel, o_penable}, 0);
    chk("rst_pwrite", o_pwrite, 0);
    chk("rst_paddr", o_paddr, 0);
    chk("rst_pwdata", o_pwdata, 0);
    chk("rst_rsp", {o_rsp_valid, o_rsp_err}, 0);
    chk("rst_rdata", o_rsp_rdata, 0);
    i_cmd_valid = 1'b0;
    i_reset_n   = 1'b1;
    step();
    chk("rel_ready", o_cmd_ready, 1);
    chk("rel_sel", o_psel, 0);
    txn(8'h3C, 1'b1, 8'hA5, 0, 1'b0, 8'h77);
    idle(1);
    txn(8'h10, 1'b0, 8'h00, 2, 1'b0, 8'h5A);
    idle(1);
    txn(8'h20, 1'b0, 8'h00, 0, 1'b1, 8'hFF);
    idle(2);
    txn(8'h44, 1'b1, 8'h77, TO + 5, 1'b0, 8'h00);
    txn(8'h55, 1'b0, 8'h00, TO - 1, 1'b0, 8'hC3);
    txn(8'h56, 1'b1, 8'h12, 1, 1'b1, 8'h00);
    idle(1);
    i_cmd_valid = 1'b1;
    i_cmd_addr  = 8'h90;
    i_cmd_write = 1'b0;
    step();
    i_cmd_valid = 1'b0;
    step();
    step();
    chk("mid_acc", {o_psel, o_penable}, 2'b11);
    i_reset_n = 1'b0;
    step();
    i_reset_n = 1'b1;
    chk("mid_sel", {o_psel, o_penable}, 0);
    chk("mid_rsp", o_rsp_valid, 0);
    chk("mid_ready", o_cmd_ready, 1);
    idle(2);
    txn(8'hA1, 1'b0, 8'h00, 1, 1'b0, 8'h3E);
    for (int t = 0; t < 60; t++) begin
      int waits;
      waits = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TO - 2, TO + 3)) : int'($urandom_range(0, 3));
      txn(8'($urandom), 1'($urandom), 8'($urandom), waits, 1'($urandom_range(0, 3) == 0), 8'($urandom));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
